spi_peripheral: RTL and testbench
=================================

Name: spi_peripheral

Overview:
- SPI target-side endpoint: receives spi_clk, cs and mosi from an external SPI master and drives miso back.
- All signals are sampled in the system clk domain.
- Full-duplex, MSB-first, DATA_WIDTH-bit frames; multiple back-to-back bytes are allowed while cs stays low.
- Supports all four CPOL/CPHA modes. Sits opposite our SPI master block on the same bus, behind a simple byte-wide handshake to local logic.

Parameters:
- DATA_WIDTH, 8, bits per frame.
- SYNC_STAGES, 2, flops in each input synchronizer (min 2).
- TX_DEFAULT, 8'hFF, byte shifted out when no tx byte is queued at frame start.

Ports:
- clk  in  1  system clock; spi_clk half-period must be >= SYNC_STAGES+1 clk cycles.
- reset  in  1  synchronous, active-high.
- polarity  in  1  CPOL; latched at cs assertion.
- phase  in  1  CPHA; latched at cs assertion.
- spi_clk  in  1  serial clock from master (asynchronous).
- cs  in  1  chip select, active low (asynchronous).
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- miso_oe  out  1  output enable for the external tri-state; 1 while selected.
- tx_data  in  DATA_WIDTH  byte to transmit.
- tx_load  in  1  write tx_data into the tx holding register.
- tx_ready  out  1  tx holding register empty.
- rx_data  out  DATA_WIDTH  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse when TX_DEFAULT is used.
- frame_error  out  1  one-cycle pulse when cs deasserts mid-byte.
- busy  out  1  in the ACTIVE state.
- count  out  4  bits remaining in the current byte (DATA_WIDTH..0).

Behaviour:
- Reset (synchronous, reset=1 at a clk edge) sets: miso=1, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_error=0, busy=0, count=DATA_WIDTH, state=IDLE, synchronizer flops=1 (cs) / CPOL-neutral 0 (spi_clk, mosi). Reset mid-frame aborts silently (no pulses).
- Synchronization: spi_clk, cs and mosi each pass through SYNC_STAGES flops. Edges are detected from the last stage against its registered copy.
- Leading edge: the transition of spi_clk away from the latched CPOL idle level. Trailing edge: the transition back to it.
- States:
  - IDLE:
    - miso_oe=0; miso=1.
    - On synchronized cs falling edge: latch {polarity,phase}; load shift_tx from the holding register (tx_ready<=1), or from TX_DEFAULT with a tx_underrun pulse if empty; count<=DATA_WIDTH; go to ACTIVE.
    - If CPHA=0, miso drives shift_tx MSB in the same cycle.
  - ACTIVE:
    - miso_oe=1; busy=1.
    - CPHA=0: sample mosi on the leading edge into shift_rx LSB and decrement count. On the trailing edge shift shift_tx left and drive the next MSB.
    - CPHA=1: on the leading edge drive shift_tx MSB (shift first, except on the first edge of a byte). Sample on the trailing edge and decrement count.
    - When count reaches 0 after a sample: rx_data<=assembled byte and rx_valid pulses the next cycle; count<=DATA_WIDTH; shift_tx reloads from the holding register or TX_DEFAULT (with tx_underrun). For CPHA=0 the new MSB is driven on that byte's final trailing edge.
    - On cs rising edge: if count==DATA_WIDTH, return to IDLE cleanly; otherwise pulse frame_error, discard the partial byte (no rx_valid) and return to IDLE.
- Holding register:
  - tx_load while tx_ready=1 captures tx_data and sets tx_ready=0.
  - tx_load while tx_ready=0 is ignored.
  - tx_load in the same cycle as a frame-start consume: the consume takes the old contents (or default); the new byte is captured for the next frame.
- polarity/phase changes while ACTIVE are ignored until the next cs assertion.
- Spurious spi_clk edges in IDLE are ignored.
- Latency: rx_valid is asserted SYNC_STAGES+2 clk cycles after the last raw sampling edge.

Decomposition:
- Shared package: SPI mode encodings (MODE0..MODE3), state enum {IDLE, ACTIVE}, DATA_WIDTH default, TX_DEFAULT.
- One sub-module, spi_input_sync: parameterised SYNC_STAGES synchronizer plus rise/fall edge detector, instantiated for spi_clk, cs and mosi.

Test Plan:
- Mode 0, spi_clk = clk/8: load 8'hA5, master sends 8'h3C -> miso carries A5 MSB-first; rx_data=8'h3C with a single rx_valid pulse; tx_ready returns to 1 at cs fall.
- Repeat for modes 1, 2 and 3 with tx 8'h5A, rx 8'hC3 -> correct data in both directions; miso transitions only on the shift edge defined for the mode.
- Two bytes under one cs low (tx 8'h11 preloaded, 8'h22 loaded mid-byte-1; rx 8'hF0, 8'h0F) -> two rx_valid pulses with F0 then 0F; miso carries 11 then 22.
- No tx_load before cs fall -> miso shifts 8'hFF, tx_underrun pulses once; rx still correct.
- cs deasserted after 5 bits -> frame_error pulse, no rx_valid, count=8, state IDLE. The next full frame of 8'h81 receives correctly.
- reset asserted mid-byte in mode 3 -> all outputs at reset values next cycle; a subsequent mode-0 frame works.

Source files
------------

// File: rtl/spi_peripheral_pkg.sv
// Shared definitions for the SPI peripheral: mode encodings, FSM states and
// default frame parameters.
package spi_peripheral_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam logic [7:0]  DEFAULT_TX         = 8'hFF;

    // {CPOL, CPHA}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

endpackage

// File: rtl/spi_peripheral_if.sv
// SPI bus lines between an external master and this peripheral.
interface spi_peripheral_if;

    logic spi_clk;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output spi_clk, output cs, output mosi, input miso, input miso_oe);
    modport slave  (input spi_clk, input cs, input mosi, output miso, output miso_oe);

endinterface

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for an asynchronous input, with rise/fall detection
// on the synchronized level.
module spi_input_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   last;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= {SYNC_STAGES{RESET_VALUE}};
            last   <= RESET_VALUE;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
            last   <= stages[SYNC_STAGES-1];
        end
    end

    assign q    = stages[SYNC_STAGES-1];
    assign rise = q & ~last;
    assign fall = ~q & last;

endmodule

// File: rtl/spi_peripheral.sv
// SPI target endpoint: full-duplex, MSB-first, all four CPOL/CPHA modes, with a
// one-deep tx holding register and byte-wide rx handshake to local logic.
module spi_peripheral
    import spi_peripheral_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_DEFAULT  = DATA_WIDTH'(DEFAULT_TX)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    input  logic                  phase,
    spi_peripheral_if.slave       bus,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_error,
    output logic                  busy,
    output logic [3:0]            count
);

    localparam logic [3:0] FULL = 4'(DATA_WIDTH);

    state_t                state;
    spi_mode_t             mode;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] shift_tx;
    logic [DATA_WIDTH-1:0] shift_rx;
    logic [DATA_WIDTH-1:0] next_tx;
    logic                  underrun_pending;
    logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic                  cpol, cpha, lead, trail, sample, shift;
    logic                  consume, load_ok;
    logic [3:0]            sync_unused;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) sclk_sync (
        .clk(clk), .reset(reset), .d(bus.spi_clk),
        .q(sync_unused[0]), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) cs_sync (
        .clk(clk), .reset(reset), .d(bus.cs),
        .q(sync_unused[1]), .rise(cs_rise), .fall(cs_fall)
    );

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) mosi_sync (
        .clk(clk), .reset(reset), .d(bus.mosi),
        .q(mosi_s), .rise(sync_unused[2]), .fall(sync_unused[3])
    );

    assign cpol = mode inside {MODE2, MODE3};
    assign cpha = mode inside {MODE1, MODE3};

    always_comb begin
        lead    = cpol ? sclk_fall : sclk_rise;
        trail   = cpol ? sclk_rise : sclk_fall;
        sample  = cpha ? trail : lead;
        shift   = cpha ? lead : trail;
        next_tx = tx_ready ? TX_DEFAULT : hold;
        consume = (state == IDLE && cs_fall) ||
                  (state == ACTIVE && !cs_rise && count == '0);
        load_ok = tx_load && (tx_ready || consume);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            mode             <= MODE0;
            hold             <= '0;
            tx_ready         <= 1'b1;
            shift_tx         <= '0;
            shift_rx         <= '0;
            underrun_pending <= 1'b0;
            bus.miso         <= 1'b1;
            bus.miso_oe      <= 1'b0;
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            tx_underrun      <= 1'b0;
            frame_error      <= 1'b0;
            busy             <= 1'b0;
            count            <= FULL;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_error <= 1'b0;

            if (load_ok) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end else if (consume) begin
                tx_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state            <= ACTIVE;
                        mode             <= spi_mode_t'({polarity, phase});
                        shift_tx         <= next_tx;
                        tx_underrun      <= tx_ready;
                        underrun_pending <= 1'b0;
                        count            <= FULL;
                        bus.miso_oe      <= 1'b1;
                        busy             <= 1'b1;
                        if (!phase) bus.miso <= next_tx[DATA_WIDTH-1];
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state       <= IDLE;
                        bus.miso    <= 1'b1;
                        bus.miso_oe <= 1'b0;
                        busy        <= 1'b0;
                        count       <= FULL;
                        if (count == '0) begin
                            rx_data  <= shift_rx;
                            rx_valid <= 1'b1;
                        end else if (count != FULL) begin
                            frame_error <= 1'b1;
                        end
                    end else if (count == '0) begin
                        // Reload now so CPHA=0 can present the MSB on the final trailing
                        // edge; the underrun is only reported once the next byte really starts.
                        rx_data          <= shift_rx;
                        rx_valid         <= 1'b1;
                        count            <= FULL;
                        shift_tx         <= next_tx;
                        underrun_pending <= tx_ready;
                    end else if (sample) begin
                        shift_rx <= {shift_rx[DATA_WIDTH-2:0], mosi_s};
                        count    <= count - 1'b1;
                        if (count == FULL) begin
                            tx_underrun      <= underrun_pending;
                            underrun_pending <= 1'b0;
                        end
                    end else if (shift) begin
                        // count==FULL here marks the first shift edge of a byte: present the
                        // freshly loaded MSB instead of shifting.
                        if (count == FULL) begin
                            bus.miso <= shift_tx[DATA_WIDTH-1];
                        end else begin
                            shift_tx <= {shift_tx[DATA_WIDTH-2:0], 1'b0};
                            bus.miso <= shift_tx[DATA_WIDTH-2];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: a bit-banged SPI master plus a
// byte-level model of the tx holding register and expected traffic.
`timescale 1ns/1ps
module tb_spi_peripheral;

    localparam int H = 4;  // spi_clk half period in clk cycles

    logic       clk = 1'b0;
    logic       reset, polarity, phase, tx_load;
    logic       tx_ready, rx_valid, tx_underrun, frame_error, busy;
    logic [7:0] tx_data, rx_data;
    logic [3:0] count;

    spi_peripheral_if bus();

    spi_peripheral #(.DATA_WIDTH(8), .SYNC_STAGES(2), .TX_DEFAULT(8'hFF)) dut (
        .clk(clk), .reset(reset), .polarity(polarity), .phase(phase), .bus(bus),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .frame_error(frame_error), .busy(busy), .count(count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse monitors
    int         n_rxv = 0, n_und = 0, n_ferr = 0;
    logic [7:0] rx_q[$];

    always @(negedge clk) begin
        if (rx_valid) begin
            n_rxv++;
            rx_q.push_back(rx_data);
        end
        if (tx_underrun) n_und++;
        if (frame_error) n_ferr++;
    end

    // Reference model: one-deep holding register, per-byte traffic tables
    bit         held;
    logic [7:0] hold_val;
    logic [7:0] mosi_b[4], exp_tx[4], got_miso[4], mid_val[4];
    bit         mid_en[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic take(output logic [7:0] v, output bit def);
        def  = !held;
        v    = held ? hold_val : 8'hFF;
        held = 1'b0;
    endtask

    task automatic half();
        repeat (H) @(negedge clk);
    endtask

    task automatic do_load(input logic [7:0] v);
        tx_data = v;
        tx_load = 1'b1;
        if (!held) begin
            held     = 1'b1;
            hold_val = v;
        end
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic frame(input int m, input int nbytes, input int last_bits);
        logic       cp, ca, m1;
        logic [7:0] v;
        bit         def;
        int         viol, nb, und_exp, nfull, base_rxv, base_und, base_ferr;
        cp = m[1];
        ca = m[0];
        polarity    = cp;
        phase       = ca;
        bus.spi_clk = cp;
        bus.mosi    = 1'b0;
        m1          = 1'b0;
        half();
        base_rxv  = n_rxv;
        base_und  = n_und;
        base_ferr = n_ferr;
        rx_q.delete();
        take(exp_tx[0], def);
        und_exp = int'(def);
        bus.cs  = 1'b0;
        if (!ca) bus.mosi = mosi_b[0][7];
        half();
        check("tx_ready_start", tx_ready, !held);
        check("busy_active", busy, 1);
        check("oe_active", bus.miso_oe, 1);
        viol = 0;
        for (int b = 0; b < nbytes; b++) begin
            nb = (b == nbytes - 1) ? last_bits : 8;
            for (int i = 0; i < nb; i++) begin
                if (!ca) begin
                    got_miso[b][7-i] = bus.miso;
                    m1 = bus.miso;
                    bus.spi_clk = ~cp;
                    half();
                    if (bus.miso !== m1) viol++;
                    bus.spi_clk = cp;
                    if (i < 7) bus.mosi = mosi_b[b][6-i];
                    else if (b + 1 < nbytes) bus.mosi = mosi_b[b+1][7];
                end else begin
                    bus.spi_clk = ~cp;
                    bus.mosi    = mosi_b[b][7-i];
                    half();
                    got_miso[b][7-i] = bus.miso;
                    m1 = bus.miso;
                    bus.spi_clk = cp;
                end
                if (mid_en[b] && i == 3) do_load(mid_val[b]);
                half();
                if (ca && bus.miso !== m1) viol++;
            end
            if (nb == 8) begin
                take(v, def);
                if (b + 1 < nbytes) begin
                    exp_tx[b+1] = v;
                    und_exp += int'(def);
                end
            end
        end
        half();
        bus.cs = 1'b1;
        repeat (8) @(negedge clk);
        nfull = (last_bits == 8) ? nbytes : nbytes - 1;
        for (int b = 0; b < nfull; b++) check("miso_byte", got_miso[b], exp_tx[b]);
        check("rx_valid_cnt", n_rxv - base_rxv, nfull);
        for (int b = 0; b < nfull; b++) begin
            if (rx_q.size() > 0) v = rx_q.pop_front();
            else v = 8'hxx;
            check("rx_byte", v, mosi_b[b]);
        end
        if (nfull > 0) check("rx_data_last", rx_data, mosi_b[nfull-1]);
        check("underrun_cnt", n_und - base_und, und_exp);
        check("frame_err_cnt", n_ferr - base_ferr, (last_bits != 8) ? 1 : 0);
        check("miso_hold_viol", viol, 0);
        check("count_idle", count, 8);
        check("busy_idle", busy, 0);
        check("oe_idle", bus.miso_oe, 0);
        check("miso_idle", bus.miso, 1);
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_miso"}, bus.miso, 1);
        check({pfx, "_oe"}, bus.miso_oe, 0);
        check({pfx, "_tx_ready"}, tx_ready, 1);
        check({pfx, "_rx_data"}, rx_data, 0);
        check({pfx, "_rx_valid"}, rx_valid, 0);
        check({pfx, "_underrun"}, tx_underrun, 0);
        check({pfx, "_frame_error"}, frame_error, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_count"}, count, 8);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_rxv, base_und, base_ferr, nb;
        reset = 1'b1; polarity = 1'b0; phase = 1'b0;
        tx_load = 1'b0; tx_data = '0;
        bus.spi_clk = 1'b0; bus.cs = 1'b1; bus.mosi = 1'b0;
        held = 1'b0; hold_val = '0;
        for (int i = 0; i < 4; i++) begin
            mid_en[i] = 1'b0;
            mid_val[i] = '0;
        end
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        half();

        // Mode 0 basic transfer
        mosi_b[0] = 8'h3C;
        do_load(8'hA5);
        check("tx_ready_loaded", tx_ready, 0);
        frame(0, 1, 8);

        // Modes 1..3
        for (int m = 1; m < 4; m++) begin
            mosi_b[0] = 8'hC3;
            do_load(8'h5A);
            frame(m, 1, 8);
        end

        // Two bytes under one cs, second tx byte loaded mid byte one
        do_load(8'h11);
        mosi_b[0] = 8'hF0; mosi_b[1] = 8'h0F;
        mid_en[0] = 1'b1; mid_val[0] = 8'h22;
        frame(0, 2, 8);
        mid_en[0] = 1'b0;

        // Underrun: nothing queued
        mosi_b[0] = 8'h96;
        frame(0, 1, 8);

        // Aborted after 5 bits, then a clean frame
        mosi_b[0] = 8'($urandom);
        frame(0, 1, 5);
        check("state_idle_after_abort", busy, 0);
        mosi_b[0] = 8'h81;
        frame(0, 1, 8);

        // Second load while full is ignored
        do_load(8'hB1);
        do_load(8'hB2);
        check("tx_ready_full", tx_ready, 0);
        mosi_b[0] = 8'h4D;
        frame(2, 1, 8);

        // Reset in the middle of a mode-3 byte
        polarity = 1'b1; phase = 1'b1; bus.spi_clk = 1'b1;
        half();
        do_load(8'h77);
        bus.cs = 1'b0;
        half();
        for (int i = 0; i < 3; i++) begin
            bus.spi_clk = 1'b0; bus.mosi = 1'($urandom); half();
            bus.spi_clk = 1'b1; half();
        end
        bus.spi_clk = 1'b0;
        @(negedge clk);
        reset = 1'b1; bus.cs = 1'b1; bus.spi_clk = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        held = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        base_rxv = n_rxv; base_und = n_und; base_ferr = n_ferr;
        repeat (12) @(negedge clk);
        check("midreset_no_rxv", n_rxv - base_rxv, 0);
        check("midreset_no_und", n_und - base_und, 0);
        check("midreset_no_ferr", n_ferr - base_ferr, 0);
        mosi_b[0] = 8'($urandom);
        do_load(8'($urandom));
        frame(0, 1, 8);

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            nb = int'($urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) do_load(8'($urandom));
            for (int b = 0; b < 4; b++) begin
                mosi_b[b]  = 8'($urandom);
                mid_en[b]  = 1'($urandom_range(0, 1));
                mid_val[b] = 8'($urandom);
            end
            frame(int'($urandom_range(0, 3)), nb, 8);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
